// File: rtl/mult_hp_arbiter_pkg.sv
// rtl/mult_hp_arbiter_pkg.sv - shared half-precision constants and arbiter helpers
//
// Purpose: constants common to the half-precision multiplier and its arbiter,
//          plus the width function used for the round-robin pointer.
// Ports:   none (package).
package mult_hp_arbiter_pkg;

    localparam int HP_W        = 16;
    localparam int HP_EXP_BIAS = 15;
    localparam logic [HP_W-1:0] HP_ONE = 16'h3C00;

    // Pointer width for a round-robin over n requesters; never narrower than one bit.
    function automatic int rr_ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_hp_rr_arb.sv
// rtl/mult_hp_rr_arb.sv - combinational round-robin priority select
//
// Purpose: picks the first asserted request at or above the pointer, wrapping
//          from NUM_REQ-1 back to 0.
// Ports:
//   req_i   [NUM_REQ-1:0]  request vector
//   ptr_i   [PW-1:0]       highest-priority index this cycle
//   gnt_o   [NUM_REQ-1:0]  one-hot grant, zero when no request
//   idx_o   [PW-1:0]       encoded index of the grant
//   any_o                  a grant was issued
module mult_hp_rr_arb
    import mult_hp_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int PW      = rr_ptr_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PW-1:0]      ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [PW-1:0]      idx_o,
    output logic               any_o
);

    logic [PW:0] sum;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        sum   = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            sum = {1'b0, ptr_i} + (PW+1)'(off);
            if (sum >= (PW+1)'(NUM_REQ)) begin
                sum = sum - (PW+1)'(NUM_REQ);
            end
            if (!any_o && req_i[sum[PW-1:0]]) begin
                any_o                = 1'b1;
                gnt_o[sum[PW-1:0]]   = 1'b1;
                idx_o                = sum[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/multhalfprecision.sv
// rtl/multhalfprecision.sv - combinational IEEE half-precision multiplier
//
// Purpose: multiplies two binary16 values, truncating the mantissa.
//          Subnormal inputs are treated as zero and underflowing results are
//          flushed to signed zero. Infinity/NaN inputs and exponent overflow
//          raise o_Exception and return a signed infinity.
// Ports:
//   i_Factor1   [15:0]  operand A
//   i_Factor2   [15:0]  operand B
//   o_Product   [15:0]  A x B
//   o_Exception         overflow or non-finite operand
module multhalfprecision
    import mult_hp_arbiter_pkg::*;
(
    input  logic [HP_W-1:0] i_Factor1,
    input  logic [HP_W-1:0] i_Factor2,
    output logic [HP_W-1:0] o_Product,
    output logic            o_Exception
);

    logic        sign;
    logic [4:0]  exp_a, exp_b;
    logic [10:0] man_a, man_b;
    logic [21:0] man_prod;
    logic [9:0]  man_res;
    logic [7:0]  exp_res;

    always_comb begin
        sign     = i_Factor1[15] ^ i_Factor2[15];
        exp_a    = i_Factor1[14:10];
        exp_b    = i_Factor2[14:10];
        man_a    = {1'b1, i_Factor1[9:0]};
        man_b    = {1'b1, i_Factor2[9:0]};
        man_prod = 22'(man_a) * 22'(man_b);
        // Product of two [1,2) mantissas lies in [1,4); bit 21 means renormalise by one.
        man_res  = man_prod[21] ? man_prod[20:11] : man_prod[19:10];
        // Max exponent sum is 61, so bit 7 unambiguously flags a negative result.
        exp_res  = 8'(exp_a) + 8'(exp_b) + 8'(man_prod[21]) - 8'(HP_EXP_BIAS);

        o_Exception = 1'b0;
        o_Product   = {sign, exp_res[4:0], man_res};
        if (exp_a == 5'h1F || exp_b == 5'h1F) begin
            o_Exception = 1'b1;
            o_Product   = {sign, 5'h1F, 10'h000};
        end else if (exp_a == 5'h00 || exp_b == 5'h00) begin
            o_Product = {sign, 15'h0000};
        end else if (exp_res[7] || exp_res == 8'd0) begin
            o_Product = {sign, 15'h0000};
        end else if (exp_res >= 8'd31) begin
            o_Exception = 1'b1;
            o_Product   = {sign, 5'h1F, 10'h000};
        end
    end

endmodule

// File: rtl/mult_hp_arbiter.sv
// rtl/mult_hp_arbiter.sv - round-robin shared half-precision multiplier, 2-stage pipeline
//
// Purpose: NUM_REQ requesters share one multhalfprecision through a round-robin
//          grant; operands register in S1, results in S2, delivered with backpressure.
// Optional: MULT_HP_ARBITER_EXC_CNT_EN adds o_ExcCount, a saturating count of
//           delivered results that carried an exception.
// Ports:
//   i_Clock, i_Reset              clock, synchronous active-high reset
//   i_ReqValid  [NUM_REQ-1:0]     per-requester operand valid
//   i_Factor1/2 [16*NUM_REQ-1:0]  packed operands, lane k at [16k+15:16k]
//   o_ReqReady  [NUM_REQ-1:0]     one-hot accept
//   o_Valid, i_Ready              result handshake
//   o_Product [15:0], o_Exception, o_Id [ID_W-1:0]  result payload
//   o_ExcCount [15:0]             exception count (optional)
module mult_hp_arbiter
    import mult_hp_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic [NUM_REQ-1:0]      i_ReqValid,
    input  logic [HP_W*NUM_REQ-1:0] i_Factor1,
    input  logic [HP_W*NUM_REQ-1:0] i_Factor2,
    output logic [NUM_REQ-1:0]      o_ReqReady,
    output logic                    o_Valid,
    input  logic                    i_Ready,
    output logic [HP_W-1:0]         o_Product,
    output logic                    o_Exception,
`ifdef MULT_HP_ARBITER_EXC_CNT_EN
    output logic [15:0]             o_ExcCount,
`endif
    output logic [ID_W-1:0]         o_Id
);

    localparam int PW = rr_ptr_w(NUM_REQ);

    logic              s1_valid_q, s1_valid_d;
    logic [HP_W-1:0]   s1_f1_q, s1_f1_d, s1_f2_q, s1_f2_d;
    logic [ID_W-1:0]   s1_id_q, s1_id_d;
    logic              s2_valid_q, s2_valid_d;
    logic [HP_W-1:0]   prod_q, prod_d;
    logic              exc_q, exc_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [PW-1:0]     ptr_q, ptr_d;

    logic              s1_adv, s2_adv, transfer;
    logic [NUM_REQ-1:0] req_gated, gnt;
    logic [PW-1:0]     gnt_idx;
    logic [HP_W-1:0]   sel_f1, sel_f2, mul_prod;
    logic              mul_exc;

    assign s2_adv = !s2_valid_q | i_Ready;
    assign s1_adv = !s1_valid_q | s2_adv;

    // No grants while S1 cannot move, and none during the reset cycle.
    assign req_gated = i_ReqValid & {NUM_REQ{s1_adv & !i_Reset}};

    mult_hp_rr_arb #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
        .req_i (req_gated),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (transfer)
    );

    assign o_ReqReady = gnt;

    // One-hot AND-OR operand select.
    always_comb begin
        sel_f1 = '0;
        sel_f2 = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_f1 = sel_f1 | (i_Factor1[k*HP_W +: HP_W] & {HP_W{gnt[k]}});
            sel_f2 = sel_f2 | (i_Factor2[k*HP_W +: HP_W] & {HP_W{gnt[k]}});
        end
    end

    multhalfprecision u_mul (
        .i_Factor1   (s1_f1_q),
        .i_Factor2   (s1_f2_q),
        .o_Product   (mul_prod),
        .o_Exception (mul_exc)
    );

    always_comb begin
        ptr_d      = ptr_q;
        s1_valid_d = s1_valid_q;
        s1_f1_d    = s1_f1_q;
        s1_f2_d    = s1_f2_q;
        s1_id_d    = s1_id_q;
        s2_valid_d = s2_valid_q;
        prod_d     = prod_q;
        exc_d      = exc_q;
        id_d       = id_q;

        if (transfer) begin
            ptr_d      = (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + PW'(1);
            s1_valid_d = 1'b1;
            s1_f1_d    = sel_f1;
            s1_f2_d    = sel_f2;
            s1_id_d    = ID_W'(gnt_idx);
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                prod_d = mul_prod;
                exc_d  = mul_exc;
                id_d   = s1_id_q;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_f1_q    <= '0;
            s1_f2_q    <= '0;
            s1_id_q    <= '0;
            s2_valid_q <= 1'b0;
            prod_q     <= '0;
            exc_q      <= 1'b0;
            id_q       <= '0;
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_f1_q    <= s1_f1_d;
            s1_f2_q    <= s1_f2_d;
            s1_id_q    <= s1_id_d;
            s2_valid_q <= s2_valid_d;
            prod_q     <= prod_d;
            exc_q      <= exc_d;
            id_q       <= id_d;
        end
    end

    assign o_Valid     = s2_valid_q;
    assign o_Product   = prod_q;
    assign o_Exception = exc_q;
    assign o_Id        = id_q;

`ifdef MULT_HP_ARBITER_EXC_CNT_EN
    logic [15:0] exc_cnt_q, exc_cnt_d;

    always_comb begin
        exc_cnt_d = exc_cnt_q;
        if (s2_valid_q && i_Ready && exc_q && exc_cnt_q != 16'hFFFF) begin
            exc_cnt_d = exc_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            exc_cnt_q <= '0;
        end else begin
            exc_cnt_q <= exc_cnt_d;
        end
    end

    assign o_ExcCount = exc_cnt_q;
`endif

endmodule

// File: tb/tb_mult_hp_arbiter.sv
// tb/tb_mult_hp_arbiter.sv - directed self-checking bench for mult_hp_arbiter
module tb_mult_hp_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [16*NUM_REQ-1:0] f1, f2;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 o_valid;
    logic                 ready;
    logic [15:0]          product;
    logic                 exc;
    logic [ID_W-1:0]      id;
`ifdef MULT_HP_ARBITER_EXC_CNT_EN
    logic [15:0]          exc_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Per-lane operand table with hand-computed products.
    logic [15:0] tab_a [NUM_REQ] = '{16'h4000, 16'h3E00, 16'h4000, 16'h3C00};
    logic [15:0] tab_b [NUM_REQ] = '{16'h4200, 16'h3E00, 16'h4000, 16'h4500};
    logic [15:0] tab_p [NUM_REQ] = '{16'h4600, 16'h4080, 16'h4400, 16'h4500};

    logic [31:0] sb_q [$];
    logic        sb_en = 1'b0;
    int          lane1_wait = 0;

    always #5 clk = ~clk;

    mult_hp_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .i_Clock     (clk),
        .i_Reset     (rst),
        .i_ReqValid  (req_valid),
        .i_Factor1   (f1),
        .i_Factor2   (f2),
        .o_ReqReady  (req_ready),
        .o_Valid     (o_valid),
        .i_Ready     (ready),
        .o_Product   (product),
        .o_Exception (exc),
`ifdef MULT_HP_ARBITER_EXC_CNT_EN
        .o_ExcCount  (exc_count),
`endif
        .o_Id        (id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic load_table;
        for (int k = 0; k < NUM_REQ; k++) begin
            f1[k*16 +: 16] = tab_a[k];
            f2[k*16 +: 16] = tab_b[k];
        end
    endtask

    // Scoreboard and fairness monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            if (o_valid && ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected", {16'(id), product}, 32'hFFFF_FFFF);
                end else begin
                    check("sb_result", {16'(id), product}, sb_q.pop_front());
                end
            end
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    sb_q.push_back({16'(k), tab_p[k]});
                    if (k == 1) begin
                        check("fair_wait", 32'(lane1_wait <= NUM_REQ - 1), 32'd1);
                        lane1_wait = 0;
                    end else begin
                        lane1_wait++;
                    end
                end
            end
        end
    end

    initial begin
        req_valid = '0;
        f1 = '0;
        f2 = '0;
        ready = 1'b1;
        rst = 1'b1;
        #1;

        // Reset state
        tick();
        check("rst_ready", 32'(req_ready), 32'h0);
        tick();
        check("rst_valid", 32'(o_valid), 32'h0);
        check("rst_prod", 32'(product), 32'h0);
        check("rst_id", 32'(id), 32'h0);
        check("rst_exc", 32'(exc), 32'h0);
`ifdef MULT_HP_ARBITER_EXC_CNT_EN
        check("rst_exccnt", 32'(exc_count), 32'h0);
`endif
        rst = 1'b0;

        // Single request, lane 0: 2.0 x 3.0
        load_table();
        req_valid = 4'b0001;
        #1;
        check("t1_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("t1_lat_early", 32'(o_valid), 32'h0);
        tick();
        check("t1_valid", 32'(o_valid), 32'h1);
        check("t1_prod", 32'(product), 32'h4600);
        check("t1_id", 32'(id), 32'h0);
        check("t1_exc", 32'(exc), 32'h0);
        tick();
        check("t1_drain", 32'(o_valid), 32'h0);

        // All lanes continuous from pointer 0
        do_reset();
        load_table();
        for (int c = 0; c < 7; c++) begin
            if (c < 5) begin
                req_valid = 4'b1111;
                #1;
                check("t2_grant", 32'(req_ready), 32'(1 << (c % 4)));
            end else begin
                req_valid = '0;
                #1;
            end
            if (c >= 2) begin
                check("t2_valid", 32'(o_valid), 32'h1);
                check("t2_id", 32'(id), 32'((c - 2) % 4));
                check("t2_prod", 32'(product), 32'(tab_p[(c - 2) % 4]));
            end
            tick();
        end
        tick();

        // Backpressure: lane 2 (1.5x1.5), lane 3 (2x2), lane 0 waiting
        f1[2*16 +: 16] = 16'h3E00; f2[2*16 +: 16] = 16'h3E00;
        f1[3*16 +: 16] = 16'h4000; f2[3*16 +: 16] = 16'h4000;
        f1[0*16 +: 16] = 16'h4000; f2[0*16 +: 16] = 16'h4200;
        ready = 1'b0;
        req_valid = 4'b1100;
        #1;
        check("t3_grant2", 32'(req_ready), 32'h4);
        tick();
        req_valid = 4'b1001;
        #1;
        check("t3_grant3", 32'(req_ready), 32'h8);
        check("t3_notyet", 32'(o_valid), 32'h0);
        tick();
        req_valid = 4'b0001;
        for (int c = 2; c < 5; c++) begin
            #1;
            check("t3_hold_valid", 32'(o_valid), 32'h1);
            check("t3_hold_prod", 32'(product), 32'h4080);
            check("t3_hold_id", 32'(id), 32'h2);
            check("t3_full_ready", 32'(req_ready), 32'h0);
            tick();
        end
        ready = 1'b1;
        #1;
        check("t3_rel_prod", 32'(product), 32'h4080);
        check("t3_rel_grant", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        check("t3_next_prod", 32'(product), 32'h4400);
        check("t3_next_id", 32'(id), 32'h3);
        tick();
        check("t3_last_prod", 32'(product), 32'h4600);
        check("t3_last_id", 32'(id), 32'h0);
        tick();
        tick();

        // Exception: 32768 x 32768 overflows
        f1[1*16 +: 16] = 16'h7800; f2[1*16 +: 16] = 16'h7800;
        req_valid = 4'b0010;
        #1;
        check("t4_grant", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        check("t4_valid", 32'(o_valid), 32'h1);
        check("t4_exc", 32'(exc), 32'h1);
        check("t4_prod", 32'(product), 32'h7C00);
        check("t4_id", 32'(id), 32'h1);
`ifdef MULT_HP_ARBITER_EXC_CNT_EN
        check("t4_cnt0", 32'(exc_count), 32'h0);
`endif
        tick();
`ifdef MULT_HP_ARBITER_EXC_CNT_EN
        check("t4_cnt1", 32'(exc_count), 32'h1);
`endif
        check("t4_drain", 32'(o_valid), 32'h0);

        // Reset with both stages full
        load_table();
        ready = 1'b0;
        req_valid = 4'b1111;
        tick();
        tick();
        check("t5_full_valid", 32'(o_valid), 32'h1);
        check("t5_full_ready", 32'(req_ready), 32'h0);
        rst = 1'b1;
        #1;
        check("t5_rst_ready", 32'(req_ready), 32'h0);
        tick();
        check("t5_rst_valid", 32'(o_valid), 32'h0);
        check("t5_rst_prod", 32'(product), 32'h0);
        rst = 1'b0;
        ready = 1'b1;
        #1;
        check("t5_ptr0", 32'(req_ready), 32'h1);
        tick();
        check("t5_ptr1", 32'(req_ready), 32'h2);
        req_valid = '0;
        tick();
        tick();
        tick();

        // Fairness with random traffic on lanes 0, 2, 3
        load_table();
        sb_q.delete();
        lane1_wait = 0;
        sb_en = 1'b1;
        for (int c = 0; c < 200; c++) begin
            req_valid = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                         1'($urandom_range(0, 1))};
            ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        ready = 1'b1;
        for (int c = 0; c < 6; c++) tick();
        check("sb_empty", 32'(sb_q.size()), 32'h0);
        sb_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mult_hp_arbiter.md
Name: mult_hp_arbiter

Overview:
- Shares one combinational half-precision multiplier, multhalfprecision, between NUM_REQ requesters.
- Uses a round-robin grant, a valid/ready handshake per requester and a 2-stage register pipeline (operand stage S1, result stage S2).
- Returns the product, the exception flag and the ID of the originating requester to a single downstream consumer with backpressure.
- Sits between the shader/vertex lanes and the multiplier in the pipeline.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must satisfy 2**ID_W >= NUM_REQ.

Ports:
- i_Clock  input  1  single clock, rising edge.
- i_Reset  input  1  synchronous, active-high reset.
- i_ReqValid  input  NUM_REQ  per-requester operand valid.
- i_Factor1  input  16*NUM_REQ  packed operand A; requester k uses bits [16k+15:16k].
- i_Factor2  input  16*NUM_REQ  packed operand B, same packing as i_Factor1.
- o_ReqReady  output  NUM_REQ  one-hot grant/accept; transfer when i_ReqValid[k] & o_ReqReady[k].
- o_Valid  output  1  result valid.
- i_Ready  input  1  downstream accept.
- o_Product  output  16  half-precision product.
- o_Exception  output  1  multiplier exception for this result.
- o_Id  output  ID_W  requester that issued this result.

Behaviour:
- Reset (synchronous, i_Reset=1 at a clock edge):
  - S1/S2 valid flags cleared; o_Valid=0, o_Product=0, o_Exception=0, o_Id=0.
  - RR pointer=0.
  - o_ReqReady=0 during the reset cycle.
  - In-flight operations are discarded.
- Stage advance:
  - s2_adv = !s2_valid | i_Ready.
  - s1_adv = !s1_valid | s2_adv.
- Arbitration (combinational):
  - If s1_adv, grant the first k with i_ReqValid[k], searching from the RR pointer upward with wrap (NUM_REQ-1 -> 0).
  - o_ReqReady is one-hot or zero and never asserts for a non-requesting lane.
  - On transfer, the pointer becomes (granted k + 1) mod NUM_REQ; otherwise the pointer holds.
- S1:
  - On transfer, register Factor1, Factor2 and ID, and set s1_valid.
  - If s1_adv with no transfer, clear s1_valid.
- Multiplier: S1 registers drive multhalfprecision combinationally.
- S2:
  - When s2_adv & s1_valid, register o_Product, o_Exception and o_Id, and set s2_valid.
  - When s2_adv & !s1_valid, clear s2_valid.
  - o_Valid = s2_valid.
- Latency: accept at edge N -> o_Valid high after edge N+1 (2 edges).
- Throughput: 1 operation/cycle with continuous i_Ready.
- Backpressure: o_Valid & !i_Ready holds o_Product/o_Exception/o_Id stable. S1 holds if full. With both stages full, o_ReqReady=0.
- Simultaneous events: S2 drain, S1->S2 move and a new S1 accept all occur in the same cycle when i_Ready=1.
- No starvation: a continuously requesting lane is granted within NUM_REQ accepts.
- Requester contract: must hold valid and operands stable until accepted.
- Exceptions: o_Exception is passed through unchanged; no retry.

Optional Feature:
- Macro: MULT_HP_ARBITER_EXC_CNT_EN.
- Defined:
  - Adds output o_ExcCount [15:0]: saturating count of results delivered (o_Valid & i_Ready) with o_Exception=1.
  - Cleared by i_Reset; holds at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package/header: half-precision constants (HP_W=16, HP_EXP_BIAS=15, HP_ONE=16'h3C00) and the RR-pointer width function.
- One sub-module, mult_hp_rr_arb: combinational round-robin priority select (request vector + pointer -> one-hot grant + encoded index).
- multhalfprecision instantiated unmodified.

Test Plan:
- Single request: lane 0, 16'h4000 x 16'h4200 (2.0x3.0), i_Ready=1 -> o_Valid two edges after accept, o_Product=16'h4600, o_Id=0, o_Exception=0.
- All 4 lanes valid continuously, i_Ready=1, pointer=0 -> grants in order 0,1,2,3,0; one result per cycle; o_Id sequence 0,1,2,3,0.
- Backpressure: lane 2 sends 16'h3E00 x 16'h3E00, lane 3 sends 16'h4000 x 16'h4000; hold i_Ready=0 for 5 cycles:
  - o_Product=16'h4080 and o_Id=2 held stable throughout;
  - o_ReqReady=0 once S1 fills;
  - after release, the next result is 16'h4400 with o_Id=3.
- Exception: 16'h7800 x 16'h7800 -> o_Exception=1, o_Id correct; with MULT_HP_ARBITER_EXC_CNT_EN, o_ExcCount increments 0->1 on handshake.
- Reset mid-operation: assert i_Reset with both stages full -> next cycle o_Valid=0; the pointer restart is checked by the following grants beginning at lane 0.
- Fairness: lane 1 held valid while lanes 0, 2 and 3 toggle randomly for 200 cycles -> each lane-1 wait <= 4 accepts; the product checker matches the reference model for every o_Id.
